// File: rtl/cvs_pkg.sv
// Shared types and constants for the CVS pattern generator and its edge-rate checker.
package cvs_pkg;

  localparam int CVS_CHANNELS = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } cvs_chk_state_t;

  // Unsigned inclusive range test; bounds arrive as 32-bit values so callers can zero-extend counts.
  function automatic logic in_range(input logic [31:0] value,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/cvs_edge_rate_checker_if.sv
// Stimulus/result bundle of the edge-rate checker: lines under test, start request, status and results.
interface cvs_edge_rate_checker_if
  import cvs_pkg::*;
#(
  parameter int CHANNELS = CVS_CHANNELS,
  parameter int COUNT_W  = 16
) ();

  logic [CHANNELS-1:0]         sig_in;
  logic                        start;
  logic                        busy;
  logic                        done;
  logic [CHANNELS-1:0]         pass;
  logic [CHANNELS*COUNT_W-1:0] counts;

  modport master (output sig_in, start, input busy, done, pass, counts);
  modport slave  (input sig_in, start, output busy, done, pass, counts);

endinterface

// File: rtl/cvs_edge_counter.sv
// One monitored line: synchroniser, edge-history flop and saturating rising-edge counter.
// Counts appear one cycle after the synced edge; clear wins over enable, no backpressure.
module cvs_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sig_async,
  input  logic               clear,
  input  logic               enable,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~hist_q;

  // History always follows the synced line, so on clear it already holds the line level
  // and a line that is high when the window opens does not count as an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
      hist_q <= synced;
      if (clear) begin
        count <= '0;
      end else if (enable && rise && (count != '1)) begin
        count <= count + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/cvs_edge_rate_checker.sv
// Counts rising edges per line over a GATE_CYCLES window and grades each count against [EXP_MIN, EXP_MAX].
// done pulses GATE_CYCLES+2 cycles after the accepted start; starts outside IDLE are dropped.
module cvs_edge_rate_checker
  import cvs_pkg::*;
#(
  parameter int CHANNELS    = CVS_CHANNELS,
  parameter int SYNC_STAGES = 2,
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_W     = 16,
  parameter int EXP_MIN     = 0,
  parameter int EXP_MAX     = 65535
) (
  input logic                    clock,
  input logic                    reset_n,
  cvs_edge_rate_checker_if.slave bus
);

  localparam int             GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]  GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]  GATE_ONE  = GW'(1);

  cvs_chk_state_t              state_q, state_d;
  logic [GW-1:0]               gate_q;
  logic                        clear;
  logic                        enable;
  logic [CHANNELS*COUNT_W-1:0] cnt_flat;
  logic [CHANNELS-1:0]         pass_d;

  logic                        busy_q;
  logic                        done_q;
  logic [CHANNELS-1:0]         pass_q;
  logic [CHANNELS*COUNT_W-1:0] counts_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [COUNT_W-1:0] cnt;

    cvs_edge_counter #(
      .SYNC_STAGES (SYNC_STAGES),
      .COUNT_W     (COUNT_W)
    ) u_cnt (
      .clock     (clock),
      .reset_n   (reset_n),
      .sig_async (bus.sig_in[i]),
      .clear     (clear),
      .enable    (enable),
      .count     (cnt)
    );

    assign cnt_flat[i*COUNT_W +: COUNT_W] = cnt;
    assign pass_d[i] = in_range(32'(cnt), 32'(EXP_MIN), 32'(EXP_MAX));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (gate_q == GATE_LAST) begin
          state_d = COMPARE;
        end
      end
      COMPARE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enable = (state_q == MEASURE);

  // Status flags are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gate_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= '0;
      counts_q <= '0;
    end else begin
      if (clear) begin
        gate_q <= '0;
      end else if (state_q == MEASURE) begin
        gate_q <= gate_q + GATE_ONE;
      end
      busy_q <= (state_d == MEASURE) || (state_d == COMPARE);
      done_q <= (state_d == DONE);
      if (state_q == COMPARE) begin
        counts_q <= cnt_flat;
        pass_q   <= pass_d;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.pass   = pass_q;
  assign bus.counts = counts_q;

endmodule

// File: tb/tb_cvs_edge_rate_checker.sv
// Randomised self-checking bench: two checker instances (16-bit and saturating 4-bit counters)
// share the stimulus; expected counts come from the sampled line history in plain arithmetic.
module tb_cvs_edge_rate_checker;

  localparam int G    = 100;
  localparam int SYNC = 2;
  localparam int CH   = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CH-1:0] drv;
  logic          jit_sig = 1'b0;
  logic          jit_en;
  int            stim_mode;
  int            ph;
  int            dens [CH];

  int            checks;
  int            errors;

  int            cyc;
  logic [CH-1:0] s_hist [0:16383];
  longint        edge_t [0:16383];
  longint        rise_q [$];

  cvs_edge_rate_checker_if #(.CHANNELS(CH), .COUNT_W(16)) bus_a ();
  cvs_edge_rate_checker_if #(.CHANNELS(CH), .COUNT_W(4))  bus_b ();

  assign bus_a.sig_in = jit_en ? {CH{jit_sig}} : drv;
  assign bus_b.sig_in = bus_a.sig_in;
  assign bus_a.start  = start;
  assign bus_b.start  = start;

  cvs_edge_rate_checker #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .GATE_CYCLES(G),
    .COUNT_W(16), .EXP_MIN(24), .EXP_MAX(26)
  ) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a.slave)
  );

  cvs_edge_rate_checker #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .GATE_CYCLES(G),
    .COUNT_W(4), .EXP_MIN(8), .EXP_MAX(15)
  ) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b.slave)
  );

  always #5 clock = ~clock;

  // Free-running jittery line with no fixed relation to clock; never toggles on a clock edge.
  always begin
    int d;
    d = $urandom_range(12, 22);
    if ((($time + d) % 5) == 0) d = d + 1;
    #d;
    jit_sig = ~jit_sig;
  end

  always @(posedge jit_sig) if (jit_en) rise_q.push_back($time);

  always @(posedge clock) begin
    s_hist[cyc] = bus_a.sig_in;
    edge_t[cyc] = $time;
    cyc = cyc + 1;
  end

  always @(negedge clock) begin
    ph = ph + 1;
    case (stim_mode)
      1: if (ph % 2 == 0) drv = ~drv;
      2: drv = ~drv;
      3: for (int i = 0; i < CH; i++) if ($urandom_range(0, 99) < dens[i]) drv[i] = ~drv[i];
      4: begin
        drv[0] = 1'b0;
        drv[4] = 1'b1;
        if (ph % 2 == 0) drv[3:1] = ~drv[3:1];
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Edges of the sampled line inside the window opened by a start accepted at clock edge a,
  // delayed by the synchroniser depth and clipped to the counter range.
  function automatic int exp_cnt(input int a, input int ch, input int w);
    int n = 0;
    for (int m = a + 1; m <= a + G; m++)
      if (s_hist[m-SYNC][ch] && !s_hist[m-SYNC-1][ch]) n++;
    if (n > (1 << w) - 1) n = (1 << w) - 1;
    return n;
  endfunction

  task automatic do_run(input string tag, input bit busy_starts, output int a);
    int dcyc, nd_a, nd_b, len, ea, eb;
    logic [CH-1:0] ep_a, ep_b;
    @(negedge clock);
    start = 1'b1;
    a = cyc;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy_on"}, bus_a.busy, 1);
    dcyc = -1; nd_a = 0; nd_b = 0;
    len = busy_starts ? 2 * G + 10 : G + 8;
    for (int k = 0; k < len; k++) begin
      if (cyc == a + G + 1) check({tag, "_busy_compare"}, bus_a.busy, 1);
      if (bus_a.done) begin
        nd_a++;
        if (dcyc < 0) begin
          dcyc = cyc;
          check({tag, "_busy_in_done"}, bus_a.busy, 0);
        end
      end
      if (bus_b.done) nd_b++;
      if (dcyc >= 0 && cyc == dcyc + 1) check({tag, "_busy_after_done"}, bus_a.busy, 0);
      start = busy_starts && ((cyc == a + 10) || bus_a.done);
      @(negedge clock);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 64'(dcyc), 64'(a + G + 2));
    check({tag, "_done_pulses_a"}, 64'(nd_a), 1);
    check({tag, "_done_pulses_b"}, 64'(nd_b), 1);
    for (int ch = 0; ch < CH; ch++) begin
      ea = exp_cnt(a, ch, 16);
      eb = exp_cnt(a, ch, 4);
      ep_a[ch] = (ea >= 24) && (ea <= 26);
      ep_b[ch] = (eb >= 8) && (eb <= 15);
      check($sformatf("%s_cnt_a%0d", tag, ch), 64'(bus_a.counts[ch*16 +: 16]), 64'(ea));
      check($sformatf("%s_cnt_b%0d", tag, ch), 64'(bus_b.counts[ch*4 +: 4]), 64'(eb));
    end
    check({tag, "_pass_a"}, 64'(bus_a.pass), 64'(ep_a));
    check({tag, "_pass_b"}, 64'(bus_b.pass), 64'(ep_b));
  endtask

  initial begin
    int a, nd, ej, obs, diff;
    longint t0;
    checks = 0; errors = 0; cyc = 0; ph = 0;
    reset_n = 1'b0; start = 1'b0; drv = '0; jit_en = 1'b0; stim_mode = 0;
    for (int i = 0; i < CH; i++) dens[i] = 0;

    repeat (3) @(negedge clock);
    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_pass", 64'(bus_a.pass), 0);
    check("rst_counts", 64'(bus_a.counts[63:0]), 0);
    check("rst_counts_b", 64'(bus_b.counts), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    stim_mode = 1; repeat (4) @(negedge clock);
    do_run("basic", 1'b0, a);
    check("basic_cnt0_nominal", 64'(bus_a.counts[15:0]), 25);

    stim_mode = 4; repeat (4) @(negedge clock);
    do_run("stuck", 1'b0, a);
    check("stuck_pass_nominal", 64'(bus_a.pass), 64'(5'b01110));

    stim_mode = 2; repeat (4) @(negedge clock);
    do_run("sat", 1'b0, a);
    check("sat_cnt_b0_nominal", 64'(bus_b.counts[3:0]), 15);

    stim_mode = 1; repeat (4) @(negedge clock);
    do_run("busy_start", 1'b1, a);

    // Abort mid-window: outputs clear at once and no done follows.
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (49) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus_a.busy, 0);
    check("abort_done", bus_a.done, 0);
    check("abort_pass", 64'(bus_a.pass), 0);
    check("abort_counts_a", 64'(bus_a.counts[63:0]), 0);
    check("abort_counts_b", 64'(bus_b.counts), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    nd = 0;
    repeat (G + 10) begin
      @(negedge clock);
      if (bus_a.done) nd++;
    end
    check("abort_no_done", 64'(nd), 0);
    do_run("after_abort", 1'b0, a);

    stim_mode = 3;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CH; i++) dens[i] = (($urandom_range(0, 4) == 0) ? 0 : $urandom_range(5, 80));
      repeat (4) @(negedge clock);
      do_run($sformatf("rand%0d", r), 1'b0, a);
    end

    stim_mode = 0;
    jit_en = 1'b1;
    rise_q.delete();
    repeat (6) @(negedge clock);
    do_run("jitter", 1'b0, a);
    t0 = edge_t[a];
    ej = 0;
    foreach (rise_q[i])
      if (rise_q[i] > t0 - SYNC * 10 && rise_q[i] <= t0 + (G - SYNC) * 10) ej++;
    for (int ch = 0; ch < CH; ch++) begin
      obs = int'(bus_a.counts[ch*16 +: 16]);
      diff = obs - ej;
      check($sformatf("jitter_within1_ch%0d_cnt%0d_ideal%0d", ch, obs, ej),
            64'((diff >= -1) && (diff <= 1)), 1);
    end
    check("jitter_no_x", 64'($isunknown(bus_a.counts)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
